audio_adc_rx: RTL

AUDIO_ADC_RX -- requirements
Module: audio_adc_rx

---
 rtl/audio_adc_rx.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/audio_adc_rx.sv
`default_nettype none
// ============================================================================
// Module      : audio_adc_rx
// Description : I2S audio ADC receiver. Deserialises 16-bit left/right
//               samples from a codec, packs stereo pairs into an 8 x 32-bit
//               FIFO and exposes DATA / STATUS / CTRL registers on an
//               Avalon-MM slave with a threshold level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_adc_rx (
   input  logic        clk,
   input  logic        reset,
   input  logic        aud_bclk,
   input  logic        aud_adclrck,
   input  logic        aud_adcdat,
   input  logic        chipselect,
   input  logic        read,
   input  logic        write,
   input  logic [1:0]  address,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        irq
);

   localparam int         FIFO_DEPTH  = 8;
   localparam logic [3:0] FIFO_FULL   = 4'd8;
   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SKIP  = 2'd1,
      SHIFT = 2'd2,
      WAIT  = 2'd3
   } state_t;

   // codec input synchronisers and bit clock edge detect
   logic [1:0]  bclk_sync;
   logic [1:0]  lrck_sync;
   logic [1:0]  dat_sync;
   logic        bclk_prev;
   logic        bclk_rise;
   logic        lrck_s;
   logic        dat_s;

   // frame deserialiser
   state_t      state;
   state_t      state_nxt;
   logic        last_lrck;
   logic        channel;
   logic [3:0]  bit_cnt;
   logic [15:0] shift_reg;
   logic [15:0] left_hold;
   logic        left_valid;
   logic        lrck_change;
   logic        word_done;
   logic [15:0] word;

   // register file and FIFO
   logic        ctrl_enable;
   logic        ctrl_irq_en;
   logic [2:0]  ctrl_thresh;
   logic        overflow;
   logic [31:0] fifo_mem [FIFO_DEPTH];
   logic [2:0]  wr_ptr;
   logic [2:0]  rd_ptr;
   logic [3:0]  count;
   logic        push;
   logic        pop;
   logic        push_ok;
   logic        drop;
   logic [31:0] push_data;
   logic        rd_access;
   logic        wr_access;
   logic [31:0] status_word;
   logic [31:0] ctrl_word;
   logic [31:0] data_word;
   logic        unused_wdata;

   assign unused_wdata = ^{writedata[31:9], writedata[7], writedata[3:2]};

   // Bring the three codec signals into the clk domain
   always_ff @(posedge clk) begin
      if (reset) begin
         bclk_sync <= 2'b00;
         lrck_sync <= 2'b00;
         dat_sync  <= 2'b00;
         bclk_prev <= 1'b0;
      end else begin
         bclk_sync <= {bclk_sync[0], aud_bclk};
         lrck_sync <= {lrck_sync[0], aud_adclrck};
         dat_sync  <= {dat_sync[0], aud_adcdat};
         bclk_prev <= bclk_sync[1];
      end
   end

   assign bclk_rise   = bclk_sync[1] & ~bclk_prev;
   assign lrck_s      = lrck_sync[1];
   assign dat_s       = dat_sync[1];
   assign lrck_change = (lrck_s != last_lrck);
   assign word        = {shift_reg[14:0], dat_s};

   // Frame FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Frame FSM next state; a channel word completes on its 16th shifted bit
   always_comb begin
      state_nxt = state;
      word_done = 1'b0;
      if (!ctrl_enable) begin
         state_nxt = IDLE;
      end else if (bclk_rise) begin
         case (state)
            IDLE: begin
               if (lrck_change) state_nxt = SKIP;
            end
            SKIP: begin
               state_nxt = SHIFT;
            end
            SHIFT: begin
               if (lrck_change) begin
                  state_nxt = SKIP;
               end else if (bit_cnt == 4'd15) begin
                  state_nxt = WAIT;
                  word_done = 1'b1;
               end
            end
            WAIT: begin
               if (lrck_change) state_nxt = SKIP;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // A right word only produces a FIFO entry when a left word precedes it
   assign push      = word_done & channel & left_valid;
   assign push_data = {left_hold, word};

   // Deserialiser datapath: shift register, bit counter, left holding register
   always_ff @(posedge clk) begin
      if (reset) begin
         last_lrck  <= 1'b0;
         channel    <= 1'b0;
         bit_cnt    <= 4'd0;
         shift_reg  <= 16'd0;
         left_hold  <= 16'd0;
         left_valid <= 1'b0;
      end else begin
         if (bclk_rise) last_lrck <= lrck_s;
         if (!ctrl_enable) begin
            bit_cnt    <= 4'd0;
            shift_reg  <= 16'd0;
            left_hold  <= 16'd0;
            left_valid <= 1'b0;
         end else if (bclk_rise) begin
            if (state_nxt == SKIP) channel <= lrck_s;
            if (state == SKIP) bit_cnt <= 4'd0;
            if ((state == SHIFT) && !lrck_change) begin
               shift_reg <= word;
               bit_cnt   <= bit_cnt + 4'd1;
            end
            if (word_done && !channel) begin
               left_hold  <= word;
               left_valid <= 1'b1;
            end
            if (push) left_valid <= 1'b0;
         end
      end
   end

   assign rd_access = chipselect & read;
   assign wr_access = chipselect & write;
   assign pop       = rd_access & (address == ADDR_DATA) & (count != 4'd0);
   // When full, a simultaneous pop frees the slot before the push lands
   assign push_ok   = push & ((count != FIFO_FULL) | pop);
   assign drop      = push & (count == FIFO_FULL) & ~pop;

   // FIFO storage, no reset so it can map onto RAM
   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr] <= push_data;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= 3'd0;
         rd_ptr <= 3'd0;
         count  <= 4'd0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 3'd1;
         if (pop)     rd_ptr <= rd_ptr + 3'd1;
         count <= count + {3'd0, push_ok} - {3'd0, pop};
      end
   end

   assign status_word = {21'd0, (count == FIFO_FULL), (count == 4'd0), overflow, 4'd0, count};
   assign ctrl_word   = {25'd0, ctrl_thresh, 2'd0, ctrl_irq_en, ctrl_enable};
   assign data_word   = (count != 4'd0) ? fifo_mem[rd_ptr] : 32'd0;

   // Register file: CTRL, sticky overflow, registered read data and irq
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_enable <= 1'b0;
         ctrl_irq_en <= 1'b0;
         ctrl_thresh <= 3'd0;
         overflow    <= 1'b0;
         readdata    <= 32'd0;
         irq         <= 1'b0;
      end else begin
         if (wr_access && (address == ADDR_CTRL)) begin
            ctrl_enable <= writedata[0];
            ctrl_irq_en <= writedata[1];
            ctrl_thresh <= writedata[6:4];
         end
         // a drop in the same cycle as a clear wins
         if (drop) begin
            overflow <= 1'b1;
         end else if (wr_access && (address == ADDR_STATUS) && writedata[8]) begin
            overflow <= 1'b0;
         end
         if (rd_access) begin
            case (address)
               ADDR_DATA:   readdata <= data_word;
               ADDR_STATUS: readdata <= status_word;
               ADDR_CTRL:   readdata <= ctrl_word;
               default:     readdata <= 32'd0;
            endcase
         end
         irq <= ctrl_irq_en & (count > {1'b0, ctrl_thresh});
      end
   end

endmodule
`default_nettype wire
